// File: rtl/simon_pkg.sv
// Shared Simon key-schedule definitions: the five published z sequences,
// the expander FSM state type and the per-width round constant.
package simon_pkg;

  // Bit 61 holds the leftmost digit of each published sequence (z[0]).
  localparam logic [61:0] Z_SEQ [0:4] = '{
    62'b11111010001001010110000111001101111101000100101011000011100110,
    62'b10001110111110010011000010110101000111011111001001100001011010,
    62'b10101111011100000011010010011000101000010001111110010110110011,
    62'b11011011101011000110010111100000010010001010011100110100001111,
    62'b11010001111001101011011000100000010111000011001010010011101111
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } kexp_state_e;

  function automatic logic [63:0] round_const(input int word_w);
    logic [63:0] ones_v;
    ones_v = 64'hFFFF_FFFF_FFFF_FFFF >> (64 - word_w);
    return ones_v & ~64'd3;
  endfunction

  function automatic logic z_bit(input int seq, input logic [5:0] pos);
    logic [61:0] z_v;
    z_v = Z_SEQ[seq];
    return z_v[6'd61 - pos];
  endfunction

endpackage

// File: rtl/simon_kexp_step.sv
// One step of the Simon key recurrence: window of the last KEY_WORDS keys
// (word 0 oldest) plus the z bit produce the next round key.
module simon_kexp_step
  import simon_pkg::*;
#(
  parameter int WORD_W    = 16,
  parameter int KEY_WORDS = 4
) (
  input  logic [KEY_WORDS*WORD_W-1:0] window,
  input  logic                        z,
  output logic [WORD_W-1:0]           key_next
);

  localparam logic [63:0]       C_FULL = round_const(WORD_W);
  localparam logic [WORD_W-1:0] C_VAL  = C_FULL[WORD_W-1:0];

  logic [WORD_W-1:0] oldest_s;
  logic [WORD_W-1:0] newest_s;
  logic [WORD_W-1:0] third_s;
  logic [WORD_W-1:0] ror3_s;
  logic [WORD_W-1:0] tmp_s;
  logic [WORD_W-1:0] mix_s;

  assign oldest_s = window[0 +: WORD_W];
  assign newest_s = window[(KEY_WORDS-1)*WORD_W +: WORD_W];
  // With four key words, word 1 of the window is k[i-3].
  assign third_s  = window[WORD_W +: WORD_W];

  assign ror3_s   = {newest_s[2:0], newest_s[WORD_W-1:3]};
  assign tmp_s    = (KEY_WORDS == 4) ? (ror3_s ^ third_s) : ror3_s;
  assign mix_s    = tmp_s ^ {tmp_s[0], tmp_s[WORD_W-1:1]};
  assign key_next = C_VAL ^ {{(WORD_W-1){1'b0}}, z} ^ oldest_s ^ mix_s;

endmodule

// File: rtl/simon_key_expander.sv
// Iterative Simon key expander streaming one round key per handshake.
// Define SIMON_KEXP_TABLE_EN to add a readable round-key table.
module simon_key_expander
  import simon_pkg::*;
#(
  parameter int WORD_W    = 16,
  parameter int KEY_WORDS = 4,
  parameter int ROUNDS    = 32,
  parameter int Z_IDX     = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [KEY_WORDS*WORD_W-1:0]   key,
  output logic                          busy,
  output logic                          rk_valid,
  input  logic                          rk_ready,
  output logic [$clog2(ROUNDS)-1:0]     rk_idx,
  output logic [WORD_W-1:0]             rk_data,
  output logic                          done
`ifdef SIMON_KEXP_TABLE_EN
  ,
  input  logic [$clog2(ROUNDS)-1:0]     rd_idx,
  output logic [WORD_W-1:0]             rd_key,
  output logic                          tbl_full
`endif
);

  localparam int                IDX_W    = $clog2(ROUNDS);
  localparam int                CNT_W    = 7;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(ROUNDS - 1);
  localparam logic [CNT_W-1:0]  M_IDX    = CNT_W'(KEY_WORDS);

  if (!((WORD_W == 16) || (WORD_W == 24) || (WORD_W == 32) ||
        (WORD_W == 48) || (WORD_W == 64))) begin : g_bad_word_w
    $error("simon_key_expander: illegal WORD_W");
  end
  if ((KEY_WORDS < 2) || (KEY_WORDS > 4)) begin : g_bad_key_words
    $error("simon_key_expander: illegal KEY_WORDS");
  end
  if ((ROUNDS < KEY_WORDS) || (ROUNDS > 72)) begin : g_bad_rounds
    $error("simon_key_expander: illegal ROUNDS");
  end
  if ((Z_IDX < 0) || (Z_IDX > 4)) begin : g_bad_z_idx
    $error("simon_key_expander: illegal Z_IDX");
  end

  kexp_state_e       state_r, state_nxt;
  logic [CNT_W-1:0]  idx_r, idx_nxt, nidx_s;
  logic [5:0]        zc_r, zc_nxt, zpos_s;
  logic [WORD_W-1:0] win_r   [KEY_WORDS];
  logic [WORD_W-1:0] win_nxt [KEY_WORDS];
  logic [WORD_W-1:0] shift_s [KEY_WORDS];
  logic [WORD_W-1:0] rk_data_r, rk_data_nxt;
  logic              rk_valid_r, rk_valid_nxt;
  logic              busy_r, busy_nxt;
  logic              done_r, done_nxt;
  logic              hs_s;
  logic              past_m_s;
  logic              z_s;
  logic [WORD_W-1:0] master_sel_s;
  logic [WORD_W-1:0] next_key_s;
  logic [KEY_WORDS*WORD_W-1:0] step_win_s;

  assign hs_s     = rk_valid_r & rk_ready;
  assign past_m_s = (idx_r >= M_IDX);
  assign nidx_s   = idx_r + 7'd1;
  assign z_s      = z_bit(Z_IDX, zpos_s);

  // Window as seen by the recurrence for the key after the current one.
  always_comb begin
    for (int j = 0; j < KEY_WORDS - 1; j++) begin
      shift_s[j] = win_r[j+1];
    end
    shift_s[KEY_WORDS-1] = rk_data_r;
    step_win_s   = '0;
    master_sel_s = '0;
    for (int j = 0; j < KEY_WORDS; j++) begin
      step_win_s[j*WORD_W +: WORD_W] = past_m_s ? shift_s[j] : win_r[j];
      master_sel_s = (CNT_W'(j) == nidx_s) ? win_r[j] : master_sel_s;
    end
    if (past_m_s) begin
      zpos_s = (zc_r == 6'd61) ? 6'd0 : (zc_r + 6'd1);
    end else begin
      zpos_s = zc_r;
    end
  end

  simon_kexp_step #(
    .WORD_W    (WORD_W),
    .KEY_WORDS (KEY_WORDS)
  ) u_step (
    .window   (step_win_s),
    .z        (z_s),
    .key_next (next_key_s)
  );

  // FSM next state and next register values; rk_data is prepared one key ahead.
  always_comb begin
    state_nxt    = state_r;
    idx_nxt      = idx_r;
    zc_nxt       = zc_r;
    rk_data_nxt  = rk_data_r;
    rk_valid_nxt = rk_valid_r;
    busy_nxt     = busy_r;
    done_nxt     = 1'b0;
    for (int j = 0; j < KEY_WORDS; j++) begin
      win_nxt[j] = win_r[j];
    end
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt    = ST_RUN;
          idx_nxt      = '0;
          zc_nxt       = '0;
          rk_data_nxt  = key[0 +: WORD_W];
          rk_valid_nxt = 1'b1;
          busy_nxt     = 1'b1;
          for (int j = 0; j < KEY_WORDS; j++) begin
            win_nxt[j] = key[j*WORD_W +: WORD_W];
          end
        end else begin
          rk_valid_nxt = 1'b0;
          busy_nxt     = 1'b0;
        end
      end
      ST_RUN: begin
        if (hs_s) begin
          if (idx_r == LAST_IDX) begin
            state_nxt    = ST_DONE;
            rk_valid_nxt = 1'b0;
            done_nxt     = 1'b1;
          end else begin
            idx_nxt     = nidx_s;
            rk_data_nxt = (nidx_s < M_IDX) ? master_sel_s : next_key_s;
            if (past_m_s) begin
              zc_nxt = zpos_s;
              for (int j = 0; j < KEY_WORDS; j++) begin
                win_nxt[j] = shift_s[j];
              end
            end else begin
              zc_nxt = zc_r;
            end
          end
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        state_nxt    = ST_IDLE;
        rk_valid_nxt = 1'b0;
        busy_nxt     = 1'b0;
      end
      default: begin
        state_nxt    = ST_IDLE;
        idx_nxt      = '0;
        zc_nxt       = '0;
        rk_data_nxt  = '0;
        rk_valid_nxt = 1'b0;
        busy_nxt     = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      idx_r      <= '0;
      zc_r       <= '0;
      rk_data_r  <= '0;
      rk_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      for (int j = 0; j < KEY_WORDS; j++) begin
        win_r[j] <= '0;
      end
    end else begin
      state_r    <= state_nxt;
      idx_r      <= idx_nxt;
      zc_r       <= zc_nxt;
      rk_data_r  <= rk_data_nxt;
      rk_valid_r <= rk_valid_nxt;
      busy_r     <= busy_nxt;
      done_r     <= done_nxt;
      for (int j = 0; j < KEY_WORDS; j++) begin
        win_r[j] <= win_nxt[j];
      end
    end
  end

  assign busy     = busy_r;
  assign rk_valid = rk_valid_r;
  assign rk_idx   = idx_r[IDX_W-1:0];
  assign rk_data  = rk_data_r;
  assign done     = done_r;

`ifdef SIMON_KEXP_TABLE_EN
  logic [WORD_W-1:0] tbl_r [ROUNDS];
  logic [WORD_W-1:0] rd_key_r;
  logic              tbl_full_r;

  // Table storage; contents survive a new start.
  always_ff @(posedge clk) begin
    if (hs_s) begin
      tbl_r[idx_r] <= rk_data_r;
    end
  end

  // Registered read port (old data on a same-index write) and full flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_key_r   <= '0;
      tbl_full_r <= 1'b0;
    end else begin
      rd_key_r <= (CNT_W'(rd_idx) < CNT_W'(ROUNDS)) ? tbl_r[rd_idx] : '0;
      if ((state_r == ST_IDLE) && start) begin
        tbl_full_r <= 1'b0;
      end else if (hs_s && (idx_r == LAST_IDX)) begin
        tbl_full_r <= 1'b1;
      end else begin
        tbl_full_r <= tbl_full_r;
      end
    end
  end

  assign rd_key   = rd_key_r;
  assign tbl_full = tbl_full_r;
`endif

endmodule

// File: tb/tb_simon_key_expander.sv
// Scoreboard bench for simon_key_expander: three variants (32/64, 128/256,
// 48/72) driven in parallel and checked against a software key schedule.
module tb_simon_key_expander;

  localparam int W0 = 16, M0 = 4, R0 = 32, Z0 = 0;
  localparam int W1 = 64, M1 = 4, R1 = 72, Z1 = 4;
  localparam int W2 = 24, M2 = 3, R2 = 36, Z2 = 0;

  localparam logic [61:0] Z_TBL [0:4] = '{
    62'b11111010001001010110000111001101111101000100101011000011100110,
    62'b10001110111110010011000010110101000111011111001001100001011010,
    62'b10101111011100000011010010011000101000010001111110010110110011,
    62'b11011011101011000110010111100000010010001010011100110100001111,
    62'b11010001111001101011011000100000010111000011001010010011101111
  };

  typedef struct packed {
    logic [7:0]  idx;
    logic [63:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic rk_ready = 1'b1;
  logic rand_ready = 1'b0;

  logic [M0*W0-1:0] key0;
  logic [M1*W1-1:0] key1;
  logic [M2*W2-1:0] key2;
  logic busy0, valid0, done0;
  logic busy1, valid1, done1;
  logic busy2, valid2, done2;
  logic [4:0]  idx0;
  logic [6:0]  idx1;
  logic [5:0]  idx2;
  logic [15:0] data0;
  logic [63:0] data1;
  logic [23:0] data2;
`ifdef SIMON_KEXP_TABLE_EN
  logic [4:0]  rd_idx0 = 5'd0;
  logic [6:0]  rd_idx1 = 7'd0;
  logic [5:0]  rd_idx2 = 6'd0;
  logic [15:0] rd_key0;
  logic [63:0] rd_key1;
  logic [23:0] rd_key2;
  logic        full0, full1, full2;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int hs0, hs1, hs2, dcnt0, dcnt1, dcnt2, done_cyc0;
  logic done_prev0 = 1'b0, done_prev1 = 1'b0, done_prev2 = 1'b0;
  logic stall0 = 1'b0;
  logic [4:0]  held_idx0;
  logic [15:0] held_data0;
  logic [15:0] obs0 [0:31];
  logic [63:0] ks0_last [0:71];
  exp_t q0[$], q1[$], q2[$];
  exp_t e0, e1, e2;

  simon_key_expander #(.WORD_W(W0), .KEY_WORDS(M0), .ROUNDS(R0), .Z_IDX(Z0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key0), .busy(busy0),
    .rk_valid(valid0), .rk_ready(rk_ready), .rk_idx(idx0), .rk_data(data0), .done(done0)
`ifdef SIMON_KEXP_TABLE_EN
    , .rd_idx(rd_idx0), .rd_key(rd_key0), .tbl_full(full0)
`endif
  );
  simon_key_expander #(.WORD_W(W1), .KEY_WORDS(M1), .ROUNDS(R1), .Z_IDX(Z1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key1), .busy(busy1),
    .rk_valid(valid1), .rk_ready(rk_ready), .rk_idx(idx1), .rk_data(data1), .done(done1)
`ifdef SIMON_KEXP_TABLE_EN
    , .rd_idx(rd_idx1), .rd_key(rd_key1), .tbl_full(full1)
`endif
  );
  simon_key_expander #(.WORD_W(W2), .KEY_WORDS(M2), .ROUNDS(R2), .Z_IDX(Z2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key2), .busy(busy2),
    .rk_valid(valid2), .rk_ready(rk_ready), .rk_idx(idx2), .rk_data(data2), .done(done2)
`ifdef SIMON_KEXP_TABLE_EN
    , .rd_idx(rd_idx2), .rd_key(rd_key2), .tbl_full(full2)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Downstream ready: constant high or a 50% coin toss each cycle.
  always @(posedge clk) begin
    #1;
    if (rand_ready) rk_ready = 1'($urandom_range(0, 1));
    else rk_ready = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ror(input logic [63:0] x, input int r, input int w,
                                      input logic [63:0] mask);
    return ((x >> r) | (x << (w - r))) & mask;
  endfunction

  // Reference key schedule written straight from the recurrence.
  function automatic void model_keys(input int w, input int m, input int rounds, input int zi,
                                     input logic [255:0] key, output logic [63:0] ks [0:71]);
    logic [63:0] mask, tmp;
    logic [61:0] zs;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    zs = Z_TBL[zi];
    for (int i = 0; i < 72; i++) ks[i] = 64'd0;
    for (int i = 0; i < m; i++) ks[i] = 64'(key >> (i * w)) & mask;
    for (int i = m; i < rounds; i++) begin
      tmp = ror(ks[i-1], 3, w, mask);
      if (m == 4) tmp = tmp ^ ks[i-3];
      tmp = tmp ^ ror(tmp, 1, w, mask);
      ks[i] = (mask & ~64'd3) ^ 64'(zs[61 - ((i - m) % 62)]) ^ ks[i-m] ^ tmp;
    end
  endfunction

  task automatic push_run();
    logic [63:0] ks [0:71];
    model_keys(W0, M0, R0, Z0, 256'(key0), ks);
    for (int i = 0; i < R0; i++) q0.push_back('{8'(i), ks[i]});
    ks0_last = ks;
    model_keys(W1, M1, R1, Z1, 256'(key1), ks);
    for (int i = 0; i < R1; i++) q1.push_back('{8'(i), ks[i]});
    model_keys(W2, M2, R2, Z2, 256'(key2), ks);
    for (int i = 0; i < R2; i++) q2.push_back('{8'(i), ks[i]});
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    push_run();
    @(posedge clk); #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic clear_counts();
    hs0 = 0; hs1 = 0; hs2 = 0; dcnt0 = 0; dcnt1 = 0; dcnt2 = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy0 || busy1 || busy2) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_eq("run_timeout", 64'(n < 1000), 64'd1);
  endtask

  task automatic end_run_checks();
    check_eq("sb0_left", 64'(q0.size()), 64'd0);
    check_eq("sb1_left", 64'(q1.size()), 64'd0);
    check_eq("sb2_left", 64'(q2.size()), 64'd0);
    check_eq("hs0_count", 64'(hs0), 64'(R0));
    check_eq("hs1_count", 64'(hs1), 64'(R1));
    check_eq("hs2_count", 64'(hs2), 64'(R2));
    check_eq("done0_count", 64'(dcnt0), 64'd1);
    check_eq("done1_count", 64'(dcnt1), 64'd1);
    check_eq("done2_count", 64'(dcnt2), 64'd1);
  endtask

  // dut0 monitor: scoreboard, stall stability, done/busy relation.
  always @(negedge clk) begin
    if (rst_n && valid0) begin
      if (stall0) begin
        check_eq("stall0_idx", 64'(idx0), 64'(held_idx0));
        check_eq("stall0_data", 64'(data0), 64'(held_data0));
      end
      stall0 = !rk_ready;
      held_idx0 = idx0;
      held_data0 = data0;
    end else begin
      stall0 = 1'b0;
    end
    if (rst_n && valid0 && rk_ready) begin
      hs0++;
      obs0[idx0] = data0;
      if (q0.size() == 0) check_eq("sb0_extra", 64'(idx0), 64'hFF);
      else begin
        e0 = q0.pop_front();
        check_eq("sb0_idx", 64'(idx0), 64'(e0.idx));
        check_eq("sb0_data", 64'(data0), e0.data);
      end
    end
    if (rst_n && done0) begin
      dcnt0++;
      done_cyc0 = cyc;
      check_eq("busy0_with_done", 64'(busy0), 64'd1);
    end
    if (rst_n && done_prev0) check_eq("busy0_after_done", 64'(busy0), 64'd0);
    done_prev0 = done0;
  end

  // dut1 monitor.
  always @(negedge clk) begin
    if (rst_n && valid1 && rk_ready) begin
      hs1++;
      if (q1.size() == 0) check_eq("sb1_extra", 64'(idx1), 64'hFF);
      else begin
        e1 = q1.pop_front();
        check_eq("sb1_idx", 64'(idx1), 64'(e1.idx));
        check_eq("sb1_data", data1, e1.data);
      end
    end
    if (rst_n && done1) dcnt1++;
    if (rst_n && done_prev1) check_eq("busy1_after_done", 64'(busy1), 64'd0);
    done_prev1 = done1;
  end

  // dut2 monitor.
  always @(negedge clk) begin
    if (rst_n && valid2 && rk_ready) begin
      hs2++;
      if (q2.size() == 0) check_eq("sb2_extra", 64'(idx2), 64'hFF);
      else begin
        e2 = q2.pop_front();
        check_eq("sb2_idx", 64'(idx2), 64'(e2.idx));
        check_eq("sb2_data", 64'(data2), e2.data);
      end
    end
    if (rst_n && done2) dcnt2++;
    if (rst_n && done_prev2) check_eq("busy2_after_done", 64'(busy2), 64'd0);
    done_prev2 = done2;
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy0"}, 64'(busy0), 64'd0);
    check_eq({tag, "_valid0"}, 64'(valid0), 64'd0);
    check_eq({tag, "_idx0"}, 64'(idx0), 64'd0);
    check_eq({tag, "_data0"}, 64'(data0), 64'd0);
    check_eq({tag, "_done0"}, 64'(done0), 64'd0);
    check_eq({tag, "_data1"}, data1, 64'd0);
    check_eq({tag, "_valid2"}, 64'(valid2), 64'd0);
`ifdef SIMON_KEXP_TABLE_EN
    check_eq({tag, "_rdkey0"}, 64'(rd_key0), 64'd0);
    check_eq({tag, "_full0"}, 64'(full0), 64'd0);
`endif
  endtask

  initial begin
    int n;
    clear_counts();
    key0 = 64'h1918_1110_0908_0100;
    key1 = 256'h1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100;
    key2 = 72'h121110_0a0908_020100;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Run 1: ready held high, published Simon32/64 vector and done latency.
    clear_counts();
    do_start();
    wait_idle();
    end_run_checks();
    check_eq("done_latency", 64'(done_cyc0 - start_cyc), 64'(R0));
    check_eq("vec_k0", 64'(obs0[0]), 64'h0100);
    check_eq("vec_k1", 64'(obs0[1]), 64'h0908);
    check_eq("vec_k2", 64'(obs0[2]), 64'h1110);
    check_eq("vec_k3", 64'(obs0[3]), 64'h1918);
    check_eq("vec_k4", 64'(obs0[4]), 64'h71C3);

    // Run 2: random backpressure, same keys.
    rand_ready = 1'b1;
    clear_counts();
    do_start();
    wait_idle();
    end_run_checks();
    rand_ready = 1'b0;

    // Run 3: ignored re-start mid-run, then reset abort at i=10.
    clear_counts();
    do_start();
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (!(valid0 && idx0 == 5'd10) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("reach_idx10", 64'(n < 200), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    repeat (2) @(posedge clk);
    #1;
    check_eq("abort_no_done0", 64'(dcnt0), 64'd0);
    check_eq("abort_no_done1", 64'(dcnt1), 64'd0);
    q0.delete(); q1.delete(); q2.delete();
    rst_n = 1'b1;

    // Run 4: fresh start with random keys regenerates from k[0].
    key0 = {$urandom(), $urandom()};
    key1 = {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
    key2 = {8'($urandom()), $urandom(), $urandom()};
    clear_counts();
    do_start();
    wait_idle();
    end_run_checks();

`ifdef SIMON_KEXP_TABLE_EN
    check_eq("tbl_full0", 64'(full0), 64'd1);
    check_eq("tbl_full2", 64'(full2), 64'd1);
    for (int i = 0; i < R0; i++) begin
      rd_idx0 = 5'(i);
      @(posedge clk); #1;
      check_eq("tbl_rd0", 64'(rd_key0), ks0_last[i]);
    end
    rd_idx2 = 6'd36;
    @(posedge clk); #1;
    check_eq("tbl_rd_oor", 64'(rd_key2), 64'd0);
    clear_counts();
    do_start();
    check_eq("tbl_full_clear", 64'(full0), 64'd0);
    wait_idle();
    end_run_checks();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
